// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART command controller.
package uart_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        LEN,
        WR_DATA,
        RD_REQ,
        RD_WAIT,
        RD_SEND,
        RESP
    } ctrl_state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_PING  = 8'h50;

    localparam logic [7:0] ACK_DEFAULT = 8'h06;
    localparam logic [7:0] NAK_DEFAULT = 8'h15;

    localparam int unsigned TIMEOUT_DEFAULT = 21477;

    // LEN byte of zero encodes a 256-byte transfer.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/uart_ctrl_timer.sv
// Inter-byte timeout counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart counting from zero (new byte seen)
//   enable     : count only while a frame is being received
//   expire_c   : combinational terminal-count pulse (count == TIMEOUT_CLKS-1)
module uart_ctrl_timer #(
    parameter int unsigned TIMEOUT_CLKS = 21477
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    logic [CW-1:0] count;

    // Disabled counter sits at zero so every frame starts a fresh window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (!expire_c) begin
            count <= count + CW'(1);
        end
    end

    assign expire_c = enable && !clear && (count == CW'(TIMEOUT_CLKS - 1));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Host command sequencer: parses UART frames (W/R/P) into memory bus
// writes/reads and returns ACK/NAK/read data through the byte transmitter.
//   rx_valid/rx_data         : received byte strobe
//   tx_valid/tx_ready/tx_data: transmit byte handshake
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata : memory bus (rdata 1 cycle after re)
//   hold_req    : stall request to the core while a W/R frame executes
//   busy        : controller not idle
//   err_timeout : one-cycle pulse on inter-byte timeout abort
//   err_overrun : sticky, a received byte was dropped
module uart_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = TIMEOUT_DEFAULT,
    parameter logic [7:0]  ACK_BYTE     = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE     = NAK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        hold_req,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_overrun
);

    ctrl_state_t state, state_d;
    logic        is_write, is_write_d;
    logic [15:0] addr, addr_d;
    logic [8:0]  count, count_d;
    logic        tx_valid_d;
    logic [7:0]  tx_data_d;
    logic [15:0] mem_addr_d;
    logic [7:0]  mem_wdata_d;
    logic        mem_we_d, mem_re_d;
    logic        hold_req_d, busy_d;
    logic        err_timeout_d, err_overrun_d;

    logic timer_en;
    logic timer_expire_c;

    assign timer_en = (state inside {ADDR_H, ADDR_L, LEN, WR_DATA});

    uart_ctrl_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rx_valid),
        .enable  (timer_en),
        .expire_c(timer_expire_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        is_write_d    = is_write;
        addr_d        = addr;
        count_d       = count;
        tx_valid_d    = tx_valid;
        tx_data_d     = tx_data;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        mem_we_d      = 1'b0;
        mem_re_d      = 1'b0;
        hold_req_d    = hold_req;
        err_timeout_d = 1'b0;
        err_overrun_d = err_overrun;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        is_write_d = (rx_data == CMD_WRITE);
                        state_d    = ADDR_H;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = (rx_data == CMD_PING) ? ACK_BYTE : NAK_BYTE;
                        state_d    = RESP;
                    end
                end
            end
            ADDR_H: begin
                if (rx_valid) begin
                    addr_d[15:8] = rx_data;
                    state_d      = ADDR_L;
                end
            end
            ADDR_L: begin
                if (rx_valid) begin
                    addr_d[7:0] = rx_data;
                    state_d     = LEN;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    count_d    = len_to_count(rx_data);
                    hold_req_d = 1'b1;
                    if (is_write) begin
                        state_d = WR_DATA;
                    end else begin
                        // mem_re is registered, so it is high for the RD_REQ cycle.
                        mem_re_d   = 1'b1;
                        mem_addr_d = addr;
                        state_d    = RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                if (rx_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr;
                    mem_wdata_d = rx_data;
                    addr_d      = addr + 16'd1;
                    count_d     = count - 9'd1;
                    if (count == 9'd1) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = ACK_BYTE;
                        hold_req_d = 1'b0;
                        state_d    = RESP;
                    end
                end
            end
            RD_REQ: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                tx_data_d  = mem_rdata;
                tx_valid_d = 1'b1;
                state_d    = RD_SEND;
            end
            RD_SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    addr_d     = addr + 16'd1;
                    count_d    = count - 9'd1;
                    if (count == 9'd1) begin
                        hold_req_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = addr + 16'd1;
                        state_d    = RD_REQ;
                    end
                end
            end
            RESP: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bytes arriving while reading back or responding are lost.
        if (rx_valid && (state inside {RD_REQ, RD_WAIT, RD_SEND, RESP})) begin
            err_overrun_d = 1'b1;
        end

        // Timer only runs in receive states with no byte this cycle.
        if (timer_expire_c) begin
            err_timeout_d = 1'b1;
            hold_req_d    = 1'b0;
            state_d       = IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            addr        <= '0;
            count       <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            hold_req    <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_d;
            is_write    <= is_write_d;
            addr        <= addr_d;
            count       <= count_d;
            tx_valid    <= tx_valid_d;
            tx_data     <= tx_data_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            mem_we      <= mem_we_d;
            mem_re      <= mem_re_d;
            hold_req    <= hold_req_d;
            busy        <= busy_d;
            err_timeout <= err_timeout_d;
            err_overrun <= err_overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames plus randomized
// frames compared against a frame-level reference model.
module tb_uart_cmd_ctrl;

    localparam int T = 21477;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        hold_req;
    logic        busy;
    logic        err_timeout;
    logic        err_overrun;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .TIMEOUT_CLKS(T),
        .ACK_BYTE    (8'h06),
        .NAK_BYTE    (8'h15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .hold_req   (hold_req),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    // Contents of never-written locations.
    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Bus-side memory: read data valid the cycle after mem_re.
    logic [7:0] bus_mem [65536];
    bit         bus_wr  [65536];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= bus_wr[mem_addr] ? bus_mem[mem_addr] : dflt(mem_addr);
        if (mem_we) begin
            bus_mem[mem_addr] <= mem_wdata;
            bus_wr[mem_addr]  <= 1'b1;
        end
    end

    // Monitor: logs bus writes, transmitted bytes and protocol violations.
    logic [23:0] wr_log [$];
    logic [7:0]  tx_log [$];
    int to_pulses, tx_viol, we_re_both, hold_cycles, stall_cnt;
    bit pv, pr, prst;
    logic [7:0] pd;
    always @(posedge clk) begin
        if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (err_timeout) to_pulses++;
        if (mem_we && mem_re) we_re_both++;
        if (hold_req) hold_cycles++;
        if (prst && pv && !pr && (!tx_valid || tx_data != pd)) tx_viol++;
        if (tx_valid && !tx_ready) stall_cnt++;
        else stall_cnt = 0;
        pv = tx_valid; pr = tx_ready; pd = tx_data; prst = rst_n;
    end

    // Transmitter model: 0 always ready, 1 random, 2 stall 20 cycles per byte, 3 never.
    int bp_mode;
    always @(negedge clk) begin
        case (bp_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(0, 2) == 0);
            2:       tx_ready = (stall_cnt >= 20);
            default: tx_ready = 1'b0;
        endcase
    end

    int n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int gmax);
        if (gmax > 0) tick($urandom_range(0, gmax));
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!busy && !tx_valid) break;
            @(negedge clk);
        end
        if (i == budget) chk("idle_wait_expired", 32'd0, 32'd1);
    endtask

    // Reference model state: what memory must hold after the frames so far.
    logic [7:0] ref_mem [65536];
    bit         ref_wr  [65536];
    logic [7:0] fdata   [256];

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_wr[a] ? ref_mem[a] : dflt(a);
    endfunction

    // Run one complete frame and compare writes/tx bytes with the model.
    task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr,
                             input int len, input int gmax, input string tag);
        int wr0, tx0, to0, h0, bad;
        logic [23:0] exp_wr [$];
        logic [7:0]  exp_tx [$];
        logic [15:0] a;
        bit is_wr;
        wr0 = wr_log.size(); tx0 = tx_log.size(); to0 = to_pulses; h0 = hold_cycles;
        is_wr = (cmd == 8'h57 || cmd == 8'h52);

        if (cmd == 8'h57) begin
            for (int i = 0; i < len; i++) begin
                a = addr + 16'(i);
                exp_wr.push_back({a, fdata[i]});
                ref_mem[a] = fdata[i];
                ref_wr[a]  = 1'b1;
            end
            exp_tx.push_back(8'h06);
        end else if (cmd == 8'h52) begin
            for (int i = 0; i < len; i++) exp_tx.push_back(ref_rd(addr + 16'(i)));
        end else if (cmd == 8'h50) begin
            exp_tx.push_back(8'h06);
        end else begin
            exp_tx.push_back(8'h15);
        end

        send_byte(cmd);
        if (is_wr) begin
            gap(gmax); send_byte(addr[15:8]);
            gap(gmax); send_byte(addr[7:0]);
            gap(gmax); send_byte(8'(len));
            if (cmd == 8'h57) begin
                for (int i = 0; i < len; i++) begin
                    gap(gmax);
                    send_byte(fdata[i]);
                end
            end
        end
        wait_idle(400 + len * 64);
        tick(2);

        chk({tag, "_wr_count"}, 32'(wr_log.size() - wr0), 32'(exp_wr.size()));
        bad = 0;
        for (int i = 0; i < exp_wr.size() && wr0 + i < wr_log.size(); i++)
            if (wr_log[wr0 + i] !== exp_wr[i]) bad++;
        chk({tag, "_wr_data_bad"}, 32'(bad), 32'd0);
        chk({tag, "_tx_count"}, 32'(tx_log.size() - tx0), 32'(exp_tx.size()));
        bad = 0;
        for (int i = 0; i < exp_tx.size() && tx0 + i < tx_log.size(); i++)
            if (tx_log[tx0 + i] !== exp_tx[i]) bad++;
        chk({tag, "_tx_data_bad"}, 32'(bad), 32'd0);
        chk({tag, "_timeouts"}, 32'(to_pulses - to0), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_hold_end"}, 32'(hold_req), 32'd0);
        // Hold spans LEN up to RESP entry: 2 cycles per back-to-back data byte.
        if (cmd == 8'h57 && gmax == 0)
            chk({tag, "_hold_cycles"}, 32'(hold_cycles - h0), 32'(2 * len));
        else
            chk({tag, "_hold_seen"}, 32'(hold_cycles > h0), 32'(is_wr));
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int hit, tx0, to0, r;
        logic [7:0]  c;
        logic [15:0] a;

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; bp_mode = 0;
        tick(3);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_hold", 32'(hold_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", {err_timeout, err_overrun}, 0);
        chk("rst_buses", {tx_data, mem_addr, mem_wdata}, 0);
        rst_n = 1'b1;
        tick(2);

        run_frame(8'h50, 16'h0000, 0, 0, "ping");

        fdata[0] = 8'hAA; fdata[1] = 8'hBB; fdata[2] = 8'hCC;
        run_frame(8'h57, 16'hFFFE, 3, 0, "wr_wrap");

        fdata[0] = 8'h5A; fdata[1] = 8'hA5;
        run_frame(8'h57, 16'h1000, 2, 0, "preload");
        bp_mode = 2;
        run_frame(8'h52, 16'h1000, 2, 0, "rd_bp");
        chk("rd_bp_tx_stable", 32'(tx_viol), 0);
        bp_mode = 0;

        for (int i = 0; i < 256; i++) fdata[i] = 8'($urandom);
        run_frame(8'h57, 16'h0000, 256, 0, "wr_len0");

        // Inter-byte timeout after a partial header.
        tx0 = tx_log.size(); to0 = to_pulses;
        send_byte(8'h57); send_byte(8'h12); send_byte(8'h34);
        hit = 0;
        for (int i = 1; i <= T + 100; i++) begin
            @(negedge clk);
            if (err_timeout) begin hit = i; break; end
        end
        chk("to_latency", 32'(hit), 32'(T));
        chk("to_busy", 32'(busy), 0);
        tick(1);
        chk("to_pulse_width", 32'(err_timeout), 0);
        tick(5);
        chk("to_pulse_count", 32'(to_pulses - to0), 1);
        chk("to_no_tx", 32'(tx_log.size() - tx0), 0);
        run_frame(8'h50, 16'h0000, 0, 0, "ping_after_to");

        run_frame(8'h41, 16'h0000, 0, 0, "unknown");

        // Byte arriving while the response is stalled is dropped.
        chk("ovr_before", 32'(err_overrun), 0);
        tx0 = tx_log.size();
        bp_mode = 3;
        send_byte(8'h50);
        send_byte(8'h77);
        chk("ovr_set", 32'(err_overrun), 1);
        chk("ovr_busy", 32'(busy), 1);
        bp_mode = 0;
        wait_idle(200);
        tick(2);
        chk("ovr_tx_count", 32'(tx_log.size() - tx0), 1);
        if (tx_log.size() > tx0) chk("ovr_tx_byte", 32'(tx_log[tx0]), 32'h06);
        chk("ovr_sticky", 32'(err_overrun), 1);

        // Randomized frames with backpressure and inter-byte gaps.
        bp_mode = 1;
        for (int f = 0; f < 24; f++) begin
            r = int'($urandom_range(0, 9));
            case ($urandom_range(0, 3))
                0: a[15:8] = 8'h00;
                1: a[15:8] = 8'h10;
                2: a[15:8] = 8'hFF;
                default: a[15:8] = 8'($urandom);
            endcase
            a[7:0] = 8'($urandom);
            if (r <= 3) c = 8'h57;
            else if (r <= 7) c = 8'h52;
            else if (r == 8) c = 8'h50;
            else begin
                c = 8'($urandom);
                while (c == 8'h57 || c == 8'h52 || c == 8'h50) c = 8'($urandom);
            end
            for (int i = 0; i < 12; i++) fdata[i] = 8'($urandom);
            run_frame(c, a, int'($urandom_range(1, 12)), 3, "rand");
        end
        bp_mode = 0;

        // Reset in the middle of a write burst.
        tx0 = tx_log.size();
        fdata[0] = 8'h11; fdata[1] = 8'h22;
        send_byte(8'h57); send_byte(8'h20); send_byte(8'h00); send_byte(8'h05);
        send_byte(fdata[0]); send_byte(fdata[1]);
        ref_mem[16'h2000] = fdata[0]; ref_wr[16'h2000] = 1'b1;
        ref_mem[16'h2001] = fdata[1]; ref_wr[16'h2001] = 1'b1;
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_outputs", {tx_valid, mem_we, mem_re, hold_req, busy, err_timeout}, 0);
        chk("mid_rst_overrun", 32'(err_overrun), 0);
        chk("mid_rst_buses", {tx_data, mem_addr, mem_wdata}, 0);
        rst_n = 1'b1;
        tick(3);
        chk("mid_rst_no_tx", 32'(tx_log.size() - tx0), 0);
        run_frame(8'h52, 16'h2000, 3, 0, "rd_after_rst");
        run_frame(8'h50, 16'h0000, 0, 0, "ping_after_rst");

        chk("tx_stable_total", 32'(tx_viol), 0);
        chk("we_re_exclusive", 32'(we_re_both), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART byte receiver/transmitter and the on-chip memory bus. It parses host frames arriving as received bytes and performs memory writes (program/CHR loading) or memory reads. It returns ACK/NAK/read data through the byte transmitter and asserts a hold request to stall the NES core during bus access. It is instantiated alongside the UART port inside the FPGA top level.

Parameters:
TIMEOUT_CLKS, 21477, inter-byte timeout in clk cycles (about 1 ms at 21.477 MHz)
ACK_BYTE, 8'h06, positive response byte
NAK_BYTE, 8'h15, negative response byte

Ports:
clk  in  1  system clock (21.477 MHz PPU clock domain)
rst_n  in  1  synchronous active-low reset
rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
rx_data  in  8  received byte
tx_valid  out  1  tx_data is presented to the transmitter
tx_ready  in  1  transmitter accepts the byte; transfer occurs when tx_valid && tx_ready
tx_data  out  8  byte to transmit
mem_addr  out  16  bus address
mem_wdata  out  8  write data
mem_we  out  1  one-cycle write strobe
mem_re  out  1  one-cycle read strobe
mem_rdata  in  8  read data, valid exactly 1 cycle after mem_re
hold_req  out  1  stall request to the NES core while a W/R frame is executing
busy  out  1  controller is not in IDLE
err_timeout  out  1  one-cycle pulse on frame abort due to timeout
err_overrun  out  1  sticky; set when an rx byte is dropped; cleared only by reset

Behaviour:
- Reset (rst_n=0 at posedge clk): state=IDLE. All outputs are 0, err_overrun is cleared, and internal address, length and timer are 0.
- Frame format: CMD, then for 'W' (8'h57) or 'R' (8'h52): ADDR_H, ADDR_L, LEN. LEN=0 means 256 bytes. 'W' is followed by LEN data bytes. 'P' (8'h50) is a ping and has no further bytes.
- IDLE: on rx_valid:
  - 'W' or 'R': latch the command and go to ADDR_H.
  - 'P': go to RESP with tx_data=ACK_BYTE.
  - Any other byte: go to RESP with tx_data=NAK_BYTE.
- ADDR_H and ADDR_L: each rx byte loads the corresponding half of the address register. After ADDR_L, go to LEN.
- LEN: latch count = (rx_data==0) ? 256 : rx_data (9-bit counter). Assert hold_req from this point. Next state: 'W' goes to WR_DATA; 'R' goes to RD_REQ.
- WR_DATA: on each rx_valid, assert mem_we for 1 cycle in the next cycle with mem_addr=addr and mem_wdata=byte. Then addr+=1 (16-bit wrap, FFFF->0000) and count-=1. When count reaches 0, go to RESP with ACK_BYTE.
- RD_REQ: assert mem_re for 1 cycle with mem_addr=addr, then go to RD_WAIT.
- RD_WAIT: capture mem_rdata into tx_data and assert tx_valid, then go to RD_SEND.
- RD_SEND: hold tx_valid and tx_data stable until tx_ready. On handshake: addr+=1 (wraps), count-=1. If count==0, go to IDLE; otherwise go to RD_REQ. No ACK is sent after reads.
- RESP: tx_valid=1 with tx_data stable until tx_ready. On handshake go to IDLE. hold_req deasserts on entry to RESP (after writes) or on return to IDLE (after reads).
- Timeout: the timer resets on every rx_valid and counts only in ADDR_H, ADDR_L, LEN and WR_DATA. When timer==TIMEOUT_CLKS-1: pulse err_timeout, deassert hold_req, go to IDLE. No response byte is sent and writes already done are not rolled back.
- Dropped bytes: rx_valid in RD_REQ, RD_WAIT, RD_SEND or RESP discards the byte and sets err_overrun. An rx_valid coinciding with the final transition into IDLE is also dropped.
- tx_valid must never drop without a handshake, except on reset.
- mem_we and mem_re are never asserted in the same cycle. Neither is asserted outside WR_DATA or RD_REQ.
- busy = (state != IDLE).
- Reset mid-frame: everything returns immediately to reset values, the partial frame is discarded, and no response is sent.

Decomposition:
- Package uart_ctrl_pkg holds:
  - state enum ctrl_state_t {IDLE, ADDR_H, ADDR_L, LEN, WR_DATA, RD_REQ, RD_WAIT, RD_SEND, RESP}
  - command constants CMD_WRITE=8'h57, CMD_READ=8'h52, CMD_PING=8'h50
  - ACK/NAK defaults
- One sub-module, uart_ctrl_timer: a loadable/clearable inter-byte timeout counter with a terminal-count pulse.

Test Plan:
- Ping: rx 8'h50 -> exactly one tx byte 8'h06, busy returns to 0, hold_req stays 0.
- Write wrap: rx 'W',FF,FE,03,AA,BB,CC -> mem_we at FFFE=AA, FFFF=BB, 0000=CC; then tx 8'h06; hold_req high from LEN until RESP.
- Read with backpressure: preload 1000..1001 = 5A,A5; rx 'R',10,00,02 with tx_ready held low 20 cycles per byte -> tx bytes 5A then A5, tx_data stable while stalled, no ACK.
- LEN=0: 'W',00,00,00 followed by 256 bytes -> 256 mem_we pulses at 0000..00FF, then 06.
- Timeout: 'W',12,34 then silence for TIMEOUT_CLKS -> err_timeout pulses once, state IDLE, no tx; a subsequent 'P' gets 06.
- Unknown command / overrun / reset: rx 8'h41 -> tx 8'h15. Byte arriving during RESP -> err_overrun=1. rst_n low mid-WR_DATA -> outputs 0 next cycle, err_overrun cleared.
